// File: rtl/mac_array_seq.sv
// Parametrised MAC array: `row` mac_row instances fed by a skewed instruction chain and
// driven by a LOAD/EXEC/FLUSH command sequencer. Define MAC_ARRAY_RELU_EN to clamp negative out_s lanes to 0.
module mac_array_seq #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int row     = 8,
    parameter int len_bw  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [len_bw-1:0]        cmd_len,
    input  logic                     cmd_mode,
    output logic                     data_req,
    input  logic [row*bw-1:0]        in_w,
    input  logic [psum_bw*col-1:0]   in_n,
    output logic [psum_bw*col-1:0]   out_s,
    output logic [col-1:0]           valid,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int span = row + col;
    localparam int tmo  = 2 * span;
    localparam int cw   = (len_bw > $clog2(tmo + 1)) ? len_bw : $clog2(tmo + 1);
    localparam logic [1:0] op_load  = 2'd0;
    localparam logic [1:0] op_exec  = 2'd1;
    localparam logic [1:0] op_flush = 2'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nxt;

    logic [1:0]        op_q;
    logic [len_bw-1:0] len_q;
    logic              mode_q;
    logic [cw-1:0]     issue_cnt, drain_cnt;
    logic [len_bw-1:0] out_cnt;
    logic              accept, issue_last, drain_ok, drain_tmo;
    logic [1:0]        inst;
    logic              row_rst;

    logic [row-1:0][1:0]            sk_inst;
    logic [row-1:0][bw-1:0]         w_lane;
    logic [row:0][psum_bw*col-1:0]  ps;
    logic [row:0][col-1:0]          vl;

    // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready; ready only in IDLE.
    assign accept     = cmd_valid && cmd_ready;
    assign issue_last = (op_q == op_flush) ? (issue_cnt == cw'(span - 1))
                                           : (issue_cnt == cw'(len_q) - cw'(1));
    assign drain_ok   = (op_q == op_exec) ? (out_cnt == len_q) : (drain_cnt == cw'(span - 1));
    assign drain_tmo  = (drain_cnt == cw'(tmo - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (cmd_len == '0 && !cmd_op[1]) ? DRAIN : ISSUE;
            ISSUE:   if (issue_last) state_nxt = DRAIN;
            DRAIN:   if (drain_ok || drain_tmo) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        data_req  = (state == ISSUE) && !op_q[1];
        inst      = 2'b00;
        if (state == ISSUE) begin
            if (op_q == op_load)      inst = 2'b01;
            else if (op_q == op_exec) inst = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= op_load;
            len_q     <= '0;
            mode_q    <= 1'b0;
            issue_cnt <= '0;
            drain_cnt <= '0;
            out_cnt   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= (state == DRAIN) && (drain_ok || drain_tmo);
            if (accept) begin
                op_q      <= cmd_op[1] ? op_flush : cmd_op;
                len_q     <= cmd_len;
                mode_q    <= cmd_mode;
                issue_cnt <= '0;
                drain_cnt <= '0;
                out_cnt   <= '0;
                err       <= 1'b0;
            end else begin
                if (state == ISSUE) issue_cnt <= issue_cnt + cw'(1);
                if (state == DRAIN) drain_cnt <= drain_cnt + cw'(1);
                if (state == DRAIN && drain_tmo && !drain_ok) err <= 1'b1;
                // Extra valid pulses past len are not counted.
                if (busy && vl[row][col-1] && out_cnt != len_q) out_cnt <= out_cnt + len_bw'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sk_inst <= '0;
        end else begin
            sk_inst[0] <= inst;
            for (int r = 1; r < row; r++) sk_inst[r] <= sk_inst[r-1];
        end
    end

    assign row_rst = ~reset;
    assign ps[0]   = in_n;
    assign vl[0]   = '1;

    for (genvar l = 0; l < row; l++) begin : g_row
        // Lane l travels through l+1 registers so it meets its instruction at row l.
        logic [l:0][bw-1:0] dl;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dl <= '0;
            end else begin
                dl[0] <= data_req ? in_w[l*bw +: bw] : '0;
                for (int i = 1; i <= l; i++) dl[i] <= dl[i-1];
            end
        end
        assign w_lane[l] = dl[l];

        mac_row #(.bw(bw), .psum_bw(psum_bw), .col(col)) u_row (
            .clk      (clk),
            .reset    (row_rst),
            .in_w     (w_lane[l]),
            .inst     (sk_inst[l]),
            .mode_sel (mode_q),
            .in_n     (ps[l]),
            .in_valid (vl[l]),
            .out_s    (ps[l+1]),
            .valid    (vl[l+1])
        );
    end

    assign valid = vl[row];
`ifdef MAC_ARRAY_RELU_EN
    for (genvar c = 0; c < col; c++) begin : g_relu
        assign out_s[c*psum_bw +: psum_bw] = ps[row][c*psum_bw + psum_bw - 1] ? '0 : ps[row][c*psum_bw +: psum_bw];
    end
`else
    assign out_s = ps[row];
`endif
endmodule

// One array row: LOAD writes successive column weights, EXEC adds in_w*weight to the north psum.
module mac_row #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int col     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [bw-1:0]          in_w,
    input  logic [1:0]             inst,
    input  logic                   mode_sel,
    input  logic [psum_bw*col-1:0] in_n,
    input  logic [col-1:0]         in_valid,
    output logic [psum_bw*col-1:0] out_s,
    output logic [col-1:0]         valid
);
    localparam int pw = (col > 1) ? $clog2(col) : 1;

    logic [col-1:0][bw-1:0]      wgt;
    logic [col-1:0][psum_bw-1:0] sum;
    logic [pw-1:0]               ptr;
    logic                        fire;

    // mode_sel=1 keeps the row silent: no psum update, no valid.
    assign fire = inst[1] && !mode_sel;

    for (genvar c = 0; c < col; c++) begin : g_col
        logic signed [2*bw-1:0] prod;
        assign prod   = $signed(in_w) * $signed(wgt[c]);
        assign sum[c] = in_n[c*psum_bw +: psum_bw] + {{(psum_bw-2*bw){prod[2*bw-1]}}, prod};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wgt   <= '0;
            ptr   <= '0;
            out_s <= '0;
            valid <= '0;
        end else begin
            valid <= fire ? in_valid : '0;
            if (fire) out_s <= sum;
            if (inst == 2'b00) begin
                ptr <= '0;
            end else if (inst[0]) begin
                wgt[ptr] <= in_w;
                ptr      <= (ptr == pw'(col - 1)) ? '0 : ptr + pw'(1);
            end
        end
    end
endmodule

// File: doc/mac_array_seq.md
# mac_array_seq

Parametrised successor to the fixed 8x8 MAC array. It instantiates `row` existing `mac_row` instances with a generated, resettable instruction-skew chain. A command sequencer drives kernel-load, execute and flush phases through a valid/ready command handshake and reports completion by counting drained outputs. It sits between the SRAM/L0 feeder and the output FIFO (OFIFO) in the core.

## Interface
- `bw`, 4: activation/weight bit width per row lane
- `psum_bw`, 16: partial-sum width per column
- `col`, 8: columns per row
- `row`, 8: number of `mac_row` instances
- `len_bw`, 8: width of the command length field
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-low reset; `mac_row` instances receive `~reset`
- `cmd_valid` input 1: command offered
- `cmd_ready` output 1: high only in IDLE
- `cmd_op` input 2: 0=LOAD, 1=EXEC, 2=FLUSH, 3=reserved (treated as FLUSH)
- `cmd_len` input len_bw: vectors to issue, 0..2^len_bw-1
- `cmd_mode` input 1: mode_sel value latched at accept, held for the whole command
- `data_req` output 1: in_w is consumed this cycle
- `in_w` input row*bw: row-lane data, used only when data_req=1, else forced to 0
- `in_n` input psum_bw*col: north psum input to row 1
- `out_s` output psum_bw*col: south psum of the last row
- `valid` output col: last-row valid bits
- `busy` output 1: state != IDLE
- `done` output 1: one-cycle completion pulse
- `err` output 1: drain timeout on the last command; held until the next accept

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - on cmd_valid&&cmd_ready, latch op, len and mode, clear counters, go to ISSUE.
  - If len=0, go to DRAIN directly.
- ISSUE: internal inst per cycle:
  - LOAD = 2'b01 with data_req=1
  - EXEC = 2'b10 with data_req=1
  - FLUSH = 2'b00 with data_req=0
  - issue_cnt counts up; after len cycles go to DRAIN.
  - FLUSH always issues `row+col` cycles regardless of len.
- DRAIN: inst=2'b00, data_req=0.
  - LOAD/FLUSH: done after exactly `row+col` drain cycles.
  - EXEC: done when out_cnt (number of cycles with valid[col-1]=1 since accept) equals len.
  - len=0 EXEC completes on the first DRAIN cycle.
  - Timeout: if drain_cnt reaches `2*(row+col)` first, pulse done with err=1.
- Skew chain: `row` registers of 2 bits each.
  - Stage 1 loads the internal inst; stage r loads stage r-1.
  - Row r sees inst r cycles after issue.
  - All stages clear to 2'b00 on reset.
- `valid[col-1]` pulses beyond len within the same command are ignored by out_cnt (saturate at len).
- cmd_valid outside IDLE is ignored; no queuing.
- Reset mid-command:
  - state returns to IDLE and all counters and the skew chain clear.
  - The command is lost; done does not pulse.

## Timing
- Reset values:
  - cmd_ready=1, busy=0, done=0, err=0, data_req=0
  - valid=0, out_s=0 (mac_row registers cleared)
- Accept at edge T: data_req first high in cycle T+1 and stays high for exactly len consecutive cycles.
- Row r receives the first instruction at edge T+1+r.
- done is registered. It is high in the single cycle in which state is IDLE again, and cmd_ready is high that same cycle. A new accept is therefore possible in the done cycle (back-to-back).
- LOAD of len L, accepted at edge T: done high in cycle T+1+L+row+col.
- mode_sel to all rows equals the latched cmd_mode from T+1 until done; it holds its value in IDLE.

## Configuration
- `MAC_ARRAY_RELU_EN`:
  - Defined: each psum_bw lane of out_s is forced to 0 when its MSB is 1 (two's-complement ReLU, combinational on the last-row output).
  - Undefined: out_s is the raw last-row psum.
  - valid is unaffected in both cases.

## Test plan
- Reset: assert reset=0 mid-EXEC with len=5 -> all outputs at reset values immediately; no done; cmd_ready=1 after release.
- LOAD len=8, in_w patterns 0x1..0x8 per row -> data_req high exactly 8 cycles; done at accept+1+8+16; err=0.
- EXEC len=4 after LOAD, in_n=0 -> valid[7] pulses 4 times; out_s matches golden dot products; done the cycle after the 4th pulse is counted; back-to-back EXEC accepted in the done cycle.
- Skew check: LOAD len=1 -> probe shows row r receives inst 2'b01 at accept+1+r for r=1..8.
- EXEC len=3 with valid forced low (kernel never loaded, mode so no outputs) -> done with err=1 after 32 drain cycles; the next accept clears err.
- With MAC_ARRAY_RELU_EN, a negative golden psum of -7 -> out_s lane = 0; without the macro -> 0xFFF9.
